// File: rtl/axis_tp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axis_tp_pkg
// Description : Shared definitions for the AXI4-Stream test-pattern blocks.
//               Contains the counter wrap function, the checker state
//               encodings and a saturating 32-bit increment.
// Revision    : 1.0 - initial release
// ============================================================================
package axis_tp_pkg;

    // Checker state encodings
    localparam logic [0:0] TP_SYNC   = 1'b0;
    localparam logic [0:0] TP_LOCKED = 1'b1;

    // Next pattern value after x.
    // The math is done in 64 bits and then masked to the stream width. Since
    // only additions and subtractions are involved, the masked result equals
    // the same computation done directly in the stream width.
    function automatic logic [63:0] tp_next(
        input logic [63:0] x,
        input logic [63:0] start_v,
        input logic [63:0] end_v,
        input logic [63:0] incr_v,
        input int unsigned width
    );
        logic [63:0] mask;
        logic [63:0] thr;
        logic [63:0] res;
        mask = (width >= 64) ? {64{1'b1}} : ((64'd1 << width) - 64'd1);
        thr  = (end_v - incr_v + 64'd1) & mask;
        if ((x & mask) >= thr) begin
            res = x + incr_v - (end_v - start_v) - 64'd1;
        end else begin
            res = x + incr_v;
        end
        return res & mask;
    endfunction

    // Increment that sticks at all-ones
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axis_ready_throttle.sv
`default_nettype none
// ============================================================================
// Module      : axis_ready_throttle
// Description : Registered tready generator. The enable input gates ready,
//               and clear gates it as well. When READY_PERIOD >= 2, ready is
//               also dropped for one cycle in every READY_PERIOD cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_ready_throttle #(
    parameter int unsigned READY_PERIOD = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic clear,
    output logic ready
);

    logic w_slot_open;
    logic r_ready;

    if (READY_PERIOD >= 2) begin : g_div
        localparam int unsigned c_div_w = (READY_PERIOD > 2) ? $clog2(READY_PERIOD) : 1;
        localparam logic [c_div_w-1:0] c_reload = c_div_w'(READY_PERIOD - 1);

        logic [c_div_w-1:0] r_div;

        // Free-running down-counter; it keeps counting while enable is low
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_div <= c_reload;
            end else if (r_div == '0) begin
                r_div <= c_reload;
            end else begin
                r_div <= r_div - 1'b1;
            end
        end

        assign w_slot_open = (r_div != '0);
    end else begin : g_no_div
        assign w_slot_open = 1'b1;
    end

    // Ready register; it is low in the first cycle out of reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ready <= 1'b0;
        end else begin
            r_ready <= enable & ~clear & w_slot_open;
        end
    end

    assign ready = r_ready;

endmodule
`default_nettype wire

// File: rtl/axis_testpattern_checker.sv
`default_nettype none
// ============================================================================
// Module      : axis_testpattern_checker
// Description : AXI4-Stream sink that locks onto a wrapped counter stream.
//               It checks each later beat against the predicted value and
//               reports lock state, beat and error counts, and the first
//               mismatch.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_testpattern_checker #(
    parameter int unsigned S00_AXIS_TDATA_WIDTH = 32,
    parameter int unsigned COUNTER_START        = 0,
    parameter int unsigned COUNTER_END          = 255,
    parameter int unsigned COUNTER_INCR         = 1,
    parameter int unsigned READY_PERIOD         = 0
) (
    input  logic                            s_axis_aclk,
    input  logic                            s_axis_aresetn,
    input  logic                            enable,
    input  logic                            clear,
    input  logic [S00_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                            s_axis_tvalid,
    output logic                            s_axis_tready,
    output logic                            locked,
    output logic                            err_pulse,
    output logic [31:0]                     beat_count,
    output logic [31:0]                     error_count,
    output logic [S00_AXIS_TDATA_WIDTH-1:0] first_err_exp,
    output logic [S00_AXIS_TDATA_WIDTH-1:0] first_err_got
);
    import axis_tp_pkg::*;

    localparam int unsigned c_w = S00_AXIS_TDATA_WIDTH;

    logic [0:0]     r_state, w_state_nxt;
    logic           r_locked, w_locked_nxt;
    logic           r_err_pulse, w_err_pulse_nxt;
    logic [31:0]    r_beat_count, w_beat_count_nxt;
    logic [31:0]    r_error_count, w_error_count_nxt;
    logic [c_w-1:0] r_expected, w_expected_nxt;
    logic [c_w-1:0] r_first_exp, w_first_exp_nxt;
    logic [c_w-1:0] r_first_got, w_first_got_nxt;

    logic           w_ready;
    logic           w_accept;
    logic           w_mismatch;
    logic [c_w-1:0] w_next_rx;
    logic [c_w-1:0] w_next_exp;

    axis_ready_throttle #(
        .READY_PERIOD (READY_PERIOD)
    ) u_throttle (
        .clk    (s_axis_aclk),
        .rst_n  (s_axis_aresetn),
        .enable (enable),
        .clear  (clear),
        .ready  (w_ready)
    );

    assign w_accept   = s_axis_tvalid & w_ready;
    assign w_mismatch = (s_axis_tdata != r_expected);
    assign w_next_rx  = c_w'(tp_next(64'(s_axis_tdata), 64'(COUNTER_START),
                                     64'(COUNTER_END), 64'(COUNTER_INCR), c_w));
    assign w_next_exp = c_w'(tp_next(64'(r_expected), 64'(COUNTER_START),
                                     64'(COUNTER_END), 64'(COUNTER_INCR), c_w));

    // State register
    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            r_state <= TP_SYNC;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic. clear always returns the FSM to SYNC
    always_comb begin
        w_state_nxt = r_state;
        if (clear) begin
            w_state_nxt = TP_SYNC;
        end else if (w_accept && (r_state == TP_SYNC)) begin
            w_state_nxt = TP_LOCKED;
        end
    end

    // Datapath next values: counters, predicted value, first-error capture
    always_comb begin
        w_locked_nxt      = r_locked;
        w_err_pulse_nxt   = 1'b0;
        w_beat_count_nxt  = r_beat_count;
        w_error_count_nxt = r_error_count;
        w_expected_nxt    = r_expected;
        w_first_exp_nxt   = r_first_exp;
        w_first_got_nxt   = r_first_got;
        if (clear) begin
            // The beat that coincides with clear is discarded
            w_locked_nxt      = 1'b0;
            w_beat_count_nxt  = '0;
            w_error_count_nxt = '0;
            w_first_exp_nxt   = '0;
            w_first_got_nxt   = '0;
        end else if (w_accept) begin
            w_beat_count_nxt = sat_inc32(r_beat_count);
            w_locked_nxt     = 1'b1;
            if (r_state == TP_SYNC) begin
                w_expected_nxt = w_next_rx;
            end else if (w_mismatch) begin
                // Resync to the received value so that one drop counts as one error
                w_err_pulse_nxt   = 1'b1;
                w_error_count_nxt = sat_inc32(r_error_count);
                w_expected_nxt    = w_next_rx;
                if (r_error_count == '0) begin
                    w_first_exp_nxt = r_expected;
                    w_first_got_nxt = s_axis_tdata;
                end
            end else begin
                w_expected_nxt = w_next_exp;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            r_locked      <= 1'b0;
            r_err_pulse   <= 1'b0;
            r_beat_count  <= '0;
            r_error_count <= '0;
            r_expected    <= '0;
            r_first_exp   <= '0;
            r_first_got   <= '0;
        end else begin
            r_locked      <= w_locked_nxt;
            r_err_pulse   <= w_err_pulse_nxt;
            r_beat_count  <= w_beat_count_nxt;
            r_error_count <= w_error_count_nxt;
            r_expected    <= w_expected_nxt;
            r_first_exp   <= w_first_exp_nxt;
            r_first_got   <= w_first_got_nxt;
        end
    end

    assign s_axis_tready = w_ready;
    assign locked        = r_locked;
    assign err_pulse     = r_err_pulse;
    assign beat_count    = r_beat_count;
    assign error_count   = r_error_count;
    assign first_err_exp = r_first_exp;
    assign first_err_got = r_first_got;

endmodule
`default_nettype wire

// File: tb/tb_axis_testpattern_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_axis_testpattern_checker
// Description : Self-checking bench for axis_testpattern_checker. It uses
//               three instances: the default range, a throttled ready, and a
//               START=10/END=20/INCR=3 range.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_testpattern_checker;

    typedef struct packed {
        logic        pulse;
        logic [31:0] beats;
        logic [31:0] errs;
        logic        locked;
        logic [31:0] fexp;
        logic [31:0] fgot;
    } exp_t;

    logic clk;
    logic rst_a, rst_bc;

    // Instance A: default parameters
    logic        a_en, a_clr, a_valid, a_ready, a_locked, a_err_pulse;
    logic [31:0] a_data, a_beats, a_errs, a_fexp, a_fgot;
    // Instance B: READY_PERIOD = 4
    logic        b_valid, b_ready, b_locked, b_err_pulse;
    logic [31:0] b_data, b_beats, b_errs, b_fexp, b_fgot;
    // Instance C: START=10, END=20, INCR=3
    logic        c_clr, c_valid, c_ready, c_locked, c_err_pulse;
    logic [31:0] c_data, c_beats, c_errs, c_fexp, c_fgot;

    int   n_vec = 0;
    int   n_err = 0;
    int   pulse_cycles = 0;
    exp_t sb_q[$];
    logic mon_acc;

    // Reference model state for instance A
    logic        m_locked;
    logic [31:0] m_exp, m_beats, m_errs, m_fexp, m_fgot;

    axis_testpattern_checker u_dut_a (
        .s_axis_aclk(clk), .s_axis_aresetn(rst_a), .enable(a_en), .clear(a_clr),
        .s_axis_tdata(a_data), .s_axis_tvalid(a_valid), .s_axis_tready(a_ready),
        .locked(a_locked), .err_pulse(a_err_pulse), .beat_count(a_beats),
        .error_count(a_errs), .first_err_exp(a_fexp), .first_err_got(a_fgot));

    axis_testpattern_checker #(.READY_PERIOD(4)) u_dut_b (
        .s_axis_aclk(clk), .s_axis_aresetn(rst_bc), .enable(1'b1), .clear(1'b0),
        .s_axis_tdata(b_data), .s_axis_tvalid(b_valid), .s_axis_tready(b_ready),
        .locked(b_locked), .err_pulse(b_err_pulse), .beat_count(b_beats),
        .error_count(b_errs), .first_err_exp(b_fexp), .first_err_got(b_fgot));

    axis_testpattern_checker #(.COUNTER_START(10), .COUNTER_END(20), .COUNTER_INCR(3)) u_dut_c (
        .s_axis_aclk(clk), .s_axis_aresetn(rst_bc), .enable(1'b1), .clear(c_clr),
        .s_axis_tdata(c_data), .s_axis_tvalid(c_valid), .s_axis_tready(c_ready),
        .locked(c_locked), .err_pulse(c_err_pulse), .beat_count(c_beats),
        .error_count(c_errs), .first_err_exp(c_fexp), .first_err_got(c_fgot));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Pattern successor for in-range values, written as a modulo walk
    function automatic logic [31:0] m_next(input logic [31:0] x, input int s, input int e, input int inc);
        int xi;
        xi = int'(x);
        return 32'(((xi - s + inc) % (e - s + 1)) + s);
    endfunction

    task automatic model_clear();
        m_locked = 1'b0; m_exp = '0; m_beats = '0; m_errs = '0; m_fexp = '0; m_fgot = '0;
    endtask

    // Update the model for a beat accepted at the coming edge and queue the expected outputs
    task automatic model_accept(input logic [31:0] d, input logic clr);
        exp_t e;
        e.pulse = 1'b0;
        if (clr) begin
            m_exp = m_exp;
            m_locked = 1'b0; m_beats = '0; m_errs = '0; m_fexp = '0; m_fgot = '0;
        end else begin
            m_beats = m_beats + 1;
            if (!m_locked) begin
                m_locked = 1'b1;
                m_exp = m_next(d, 0, 255, 1);
            end else if (d != m_exp) begin
                e.pulse = 1'b1;
                if (m_errs == 0) begin
                    m_fexp = m_exp;
                    m_fgot = d;
                end
                m_errs = m_errs + 1;
                m_exp = m_next(d, 0, 255, 1);
            end else begin
                m_exp = m_next(m_exp, 0, 255, 1);
            end
        end
        e.beats = m_beats; e.errs = m_errs; e.locked = m_locked; e.fexp = m_fexp; e.fgot = m_fgot;
        sb_q.push_back(e);
    endtask

    // Scoreboard monitor for instance A: check the outputs 1 time unit after each edge
    always @(posedge clk) begin
        exp_t e;
        mon_acc = a_valid & a_ready & rst_a;
        #1;
        if (mon_acc) begin
            if (sb_q.size() == 0) begin
                check_val("sb_underflow", 1, 0);
            end else begin
                e = sb_q.pop_front();
                check_val("a_err_pulse", a_err_pulse, e.pulse);
                check_val("a_beat_count", a_beats, e.beats);
                check_val("a_error_count", a_errs, e.errs);
                check_val("a_locked", a_locked, e.locked);
                check_val("a_first_err_exp", a_fexp, e.fexp);
                check_val("a_first_err_got", a_fgot, e.fgot);
            end
        end else begin
            check_val("a_idle_pulse", a_err_pulse, 0);
        end
        if (a_err_pulse) pulse_cycles++;
    end

    // Offer one beat to A (called at a negedge; returns at a negedge)
    task automatic drive_a(input logic [31:0] d, input logic clr);
        bit done;
        done = 0;
        a_data = d; a_valid = 1'b1; a_clr = clr;
        for (int i = 0; i < 50 && !done; i++) begin
            if (a_ready) begin
                model_accept(d, clr);
                done = 1;
            end
            @(negedge clk);
        end
        if (!done) check_val("a_timeout", 0, 1);
        a_valid = 1'b0; a_clr = 1'b0;
    endtask

    task automatic drive_c(input logic [31:0] d);
        bit done;
        done = 0;
        c_data = d; c_valid = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            if (c_ready) done = 1;
            @(negedge clk);
        end
        if (!done) check_val("c_timeout", 0, 1);
        c_valid = 1'b0;
    endtask

    initial begin
        int p0;
        int took, acc_cnt;
        logic [31:0] x;
        rst_a = 1'b0; rst_bc = 1'b0;
        a_en = 1'b1; a_clr = 1'b0; a_valid = 1'b0; a_data = '0;
        b_valid = 1'b0; b_data = '0;
        c_clr = 1'b0; c_valid = 1'b0; c_data = '0;
        model_clear();
        repeat (3) @(negedge clk);

        // Reset values
        check_val("rst_ready", a_ready, 0);
        check_val("rst_locked", a_locked, 0);
        check_val("rst_beats", a_beats, 0);
        check_val("rst_errs", a_errs, 0);
        rst_a = 1'b1;
        check_val("rst_rel_ready0", a_ready, 0);
        @(negedge clk);
        check_val("rst_rel_ready1", a_ready, 1);

        // 600 beats of the clean wrapped counter
        x = 0;
        for (int i = 0; i < 600; i++) begin
            drive_a(x, 1'b0);
            x = m_next(x, 0, 255, 1);
        end
        check_val("gen_beats600", a_beats, 600);
        check_val("gen_errs0", a_errs, 0);
        check_val("gen_locked", a_locked, 1);
        check_val("gen_no_pulse", pulse_cycles, 0);

        // clear without a beat, then 5,6,8,9 with 7 dropped
        a_clr = 1'b1;
        @(negedge clk);
        a_clr = 1'b0;
        model_clear();
        check_val("clr_errs", a_errs, 0);
        check_val("clr_locked", a_locked, 0);
        p0 = pulse_cycles;
        drive_a(5, 1'b0); drive_a(6, 1'b0); drive_a(8, 1'b0); drive_a(9, 1'b0);
        check_val("drop_errs", a_errs, 1);
        check_val("drop_fexp", a_fexp, 7);
        check_val("drop_fgot", a_fgot, 8);
        check_val("drop_pulse_len", pulse_cycles - p0, 1);

        // enable low: tready drops and no beats are taken
        a_en = 1'b0;
        @(negedge clk);
        check_val("en_ready_low", a_ready, 0);
        a_data = 10; a_valid = 1'b1;
        repeat (3) @(negedge clk);
        check_val("en_hold_beats", a_beats, 4);
        a_en = 1'b1;
        drive_a(10, 1'b0);
        check_val("en_resume_errs", a_errs, 1);

        // clear on the same edge as a mismatching beat, then relock
        drive_a(50, 1'b1);
        check_val("clrmis_errs", a_errs, 0);
        check_val("clrmis_locked", a_locked, 0);
        drive_a(60, 1'b0);
        check_val("relock_locked", a_locked, 1);
        check_val("relock_errs", a_errs, 0);

        // Asynchronous reset in the middle of a beat
        a_data = 61; a_valid = 1'b1;
        #2 rst_a = 1'b0;
        #1;
        check_val("arst_ready", a_ready, 0);
        check_val("arst_locked", a_locked, 0);
        check_val("arst_pulse", a_err_pulse, 0);
        check_val("arst_beats", a_beats, 0);
        check_val("arst_errs", a_errs, 0);
        check_val("arst_fexp", a_fexp, 0);
        check_val("arst_fgot", a_fgot, 0);
        sb_q.delete();
        model_clear();
        repeat (2) @(negedge clk);
        rst_a = 1'b1;
        check_val("arst_rel_ready0", a_ready, 0);
        @(negedge clk);
        check_val("arst_rel_ready1", a_ready, 1);
        drive_a(77, 1'b0);
        check_val("arst_relock", a_locked, 1);
        check_val("arst_beat1", a_beats, 1);

        // Instance B: tready is low in every 4th cycle, and the stream stays clean
        b_valid = 1'b1; b_data = 0;
        took = 0; acc_cnt = 0;
        rst_bc = 1'b1;
        for (int n = 1; n <= 1000; n++) begin
            @(negedge clk);
            if (took != 0) begin
                b_data = m_next(b_data, 0, 255, 1);
                acc_cnt++;
            end
            took = int'(b_ready);
            check_val("b_ready_pattern", b_ready, (n % 4) != 0);
        end
        @(negedge clk);
        if (took != 0) acc_cnt++;
        b_valid = 1'b0;
        check_val("b_errs", b_errs, 0);
        check_val("b_beats", b_beats, acc_cnt);
        check_val("b_locked", b_locked, 1);

        // Instance C: wrap from 19 to 11 is clean; 12 in place of 11 is an error
        drive_c(10); drive_c(13); drive_c(16); drive_c(19); drive_c(11);
        check_val("c_wrap_errs", c_errs, 0);
        check_val("c_wrap_beats", c_beats, 5);
        c_clr = 1'b1;
        @(negedge clk);
        c_clr = 1'b0;
        drive_c(10); drive_c(13); drive_c(16); drive_c(19); drive_c(12);
        check_val("c_bad_errs", c_errs, 1);
        check_val("c_bad_fexp", c_fexp, 11);
        check_val("c_bad_fgot", c_fgot, 12);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
